// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/MEM memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Arbiter FSM: idle, data access outstanding, fetch outstanding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants taken while a fetch was waiting.
module mem_arb_starve_ctr #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [3:0] MAX_C = 4'(MAX);

    logic [3:0] cnt_q, cnt_d;

    assign at_max = (cnt_q >= MAX_C);

    // Clear wins over increment; increment saturates at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = 4'd0;
        else if (inc && !at_max)
            cnt_d = cnt_q + 4'd1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= 4'd0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access,
// with pipeline stall generation and flush of an in-flight fetch.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    input  logic              flush,
    output logic              stall_if,
    output logic              stall_all,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_e        state_q;
    logic              discard_q;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic              if_valid_q, d_done_q;

    logic d_elig, i_elig, at_max;
    logic grant_d, grant_f, starve_inc, complete;

    // A request seen alongside its own completion pulse belongs to the
    // retiring instruction, so it must not start a second access.
    assign d_elig = d_req  & ~d_done_q;
    assign i_elig = if_req & ~if_valid_q;

    // Grant decision in IDLE: data first unless fetch has waited too long.
    always_comb begin
        grant_d    = 1'b0;
        grant_f    = 1'b0;
        starve_inc = 1'b0;
        if (state_q == IDLE) begin
            if (d_elig && (!i_elig || !at_max)) begin
                grant_d    = 1'b1;
                starve_inc = i_elig;
            end else if (i_elig) begin
                grant_f = 1'b1;
            end
        end
    end

    assign complete = mem_req_q & mem_ready;

    mem_arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (starve_inc),
        .clr    (grant_f),
        .at_max (at_max)
    );

    // FSM with registered memory-side and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            discard_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            d_done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q     <= DATA;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                    end else if (grant_f) begin
                        state_q    <= FETCH;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= if_addr;
                    end
                end
                DATA: begin
                    if (complete) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        d_done_q  <= 1'b1;
                        if (!mem_we_q)
                            d_rdata_q <= mem_rdata;
                    end
                end
                FETCH: begin
                    // Memory cannot cancel a fetch; a flushed one runs to
                    // completion and its response is simply dropped.
                    if (complete) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        discard_q <= 1'b0;
                        if (!discard_q && !flush) begin
                            if_rdata_q <= mem_rdata;
                            if_valid_q <= 1'b1;
                        end
                    end else if (flush) begin
                        discard_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_rdata   = d_rdata_q;
    assign d_done    = d_done_q;

    // Stalls are forced low during reset so every output reads 0 there.
    assign stall_all = rst_n & d_req & ~d_done_q;
    assign stall_if  = rst_n & ((if_req & ~if_valid_q) | stall_all);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (STARVE_MAX = 2).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we, flush, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_valid, d_done, stall_if, stall_all, mem_req, mem_we;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .flush     (flush),
        .stall_if  (stall_if),
        .stall_all (stall_all),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; if_req = 0; d_req = 0; d_we = 0; flush = 0; mem_ready = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
        #2;
        chk("rst_mem_req",  32'(mem_req), 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_d_done",   32'(d_done), 32'h0);
        chk("rst_stall_if", 32'(stall_if), 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        step(); step();
        rst_n = 1'b1;

        // ---- single fetch ----
        if_req = 1; if_addr = 32'h40;
        #1 chk("f1_stall_if_wait", 32'(stall_if), 32'h1);
        step();
        chk("f1_mem_req", 32'(mem_req), 32'h1);
        chk("f1_mem_addr", mem_addr, 32'h40);
        chk("f1_mem_we", 32'(mem_we), 32'h0);
        step();
        chk("f1_mem_req_hold", 32'(mem_req), 32'h1);
        mem_ready = 1; mem_rdata = 32'h8C010004;
        step();
        chk("f1_if_valid", 32'(if_valid), 32'h1);
        chk("f1_if_rdata", if_rdata, 32'h8C010004);
        chk("f1_stall_if_done", 32'(stall_if), 32'h0);
        chk("f1_mem_req_low", 32'(mem_req), 32'h0);
        if_req = 0; mem_ready = 0;
        step();
        chk("f1_if_valid_pulse", 32'(if_valid), 32'h0);

        // ---- simultaneous requests: data wins, fetch follows ----
        d_req = 1; d_we = 0; d_addr = 32'h100; if_req = 1; if_addr = 32'h44;
        #1 chk("sim_stall_all", 32'(stall_all), 32'h1);
        step();
        chk("sim_data_addr", mem_addr, 32'h100);
        chk("sim_data_we", 32'(mem_we), 32'h0);
        chk("sim_stall_all_hold", 32'(stall_all), 32'h1);
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        step();
        chk("sim_d_done", 32'(d_done), 32'h1);
        chk("sim_d_rdata", d_rdata, 32'hDEADBEEF);
        chk("sim_stall_all_rel", 32'(stall_all), 32'h0);
        d_req = 0; mem_ready = 0;
        step();
        chk("sim_fetch_req", 32'(mem_req), 32'h1);
        chk("sim_fetch_addr", mem_addr, 32'h44);
        chk("sim_d_done_pulse", 32'(d_done), 32'h0);
        mem_ready = 1; mem_rdata = 32'h11111111;
        step();
        chk("sim_if_valid", 32'(if_valid), 32'h1);
        chk("sim_if_rdata", if_rdata, 32'h11111111);
        if_req = 0; mem_ready = 0;
        step();

        // ---- starvation: DATA, DATA, FETCH with STARVE_MAX = 2 ----
        d_req = 1; d_addr = 32'h200; if_req = 1; if_addr = 32'h48;
        step();
        chk("stv_g1_data", mem_addr, 32'h200);
        mem_ready = 1; mem_rdata = 32'hA;
        step();
        chk("stv_g1_done", 32'(d_done), 32'h1);
        if_req = 0; mem_ready = 0; d_addr = 32'h204;
        step();
        chk("stv_gap1_idle", 32'(mem_req), 32'h0);
        if_req = 1;
        step();
        chk("stv_g2_data", mem_addr, 32'h204);
        chk("stv_g2_req", 32'(mem_req), 32'h1);
        mem_ready = 1; mem_rdata = 32'hB;
        step();
        chk("stv_g2_done", 32'(d_done), 32'h1);
        if_req = 0; mem_ready = 0; d_addr = 32'h208;
        step();
        chk("stv_gap2_idle", 32'(mem_req), 32'h0);
        if_req = 1;
        step();
        chk("stv_g3_fetch", mem_addr, 32'h48);
        chk("stv_g3_we", 32'(mem_we), 32'h0);
        mem_ready = 1; mem_rdata = 32'h22222222;
        step();
        chk("stv_g3_if_valid", 32'(if_valid), 32'h1);
        chk("stv_g3_stall_all", 32'(stall_all), 32'h1);
        if_req = 0; mem_ready = 0;
        step();
        chk("stv_g4_data", mem_addr, 32'h208);
        mem_ready = 1; mem_rdata = 32'hC;
        step();
        chk("stv_g4_d_rdata", d_rdata, 32'hC);
        d_req = 0; mem_ready = 0;
        step();

        // ---- flush mid-fetch ----
        if_req = 1; if_addr = 32'h60;
        step();
        chk("fl_issue", 32'(mem_req), 32'h1);
        flush = 1;
        step();
        flush = 0;
        chk("fl_hold", 32'(mem_req), 32'h1);
        mem_ready = 1; mem_rdata = 32'h0BAD0BAD;
        step();
        chk("fl_no_valid", 32'(if_valid), 32'h0);
        chk("fl_rdata_kept", if_rdata, 32'h22222222);
        chk("fl_req_low", 32'(mem_req), 32'h0);
        if_addr = 32'h80; mem_ready = 0;
        step();
        chk("fl_refetch_addr", mem_addr, 32'h80);
        mem_ready = 1; mem_rdata = 32'h33333333;
        step();
        chk("fl_refetch_valid", 32'(if_valid), 32'h1);
        chk("fl_refetch_rdata", if_rdata, 32'h33333333);
        if_req = 0; mem_ready = 0;
        step();

        // ---- store ----
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h5;
        step();
        chk("st_we", 32'(mem_we), 32'h1);
        chk("st_addr", mem_addr, 32'h20);
        chk("st_wdata", mem_wdata, 32'h5);
        d_addr = 32'h999; d_wdata = 32'h777;
        step();
        chk("st_addr_stable", mem_addr, 32'h20);
        chk("st_wdata_stable", mem_wdata, 32'h5);
        mem_ready = 1; mem_rdata = 32'hFFFFFFFF;
        step();
        chk("st_done", 32'(d_done), 32'h1);
        chk("st_rdata_kept", d_rdata, 32'hC);
        d_req = 0; d_we = 0; mem_ready = 0;
        step();

        // ---- reset mid-access ----
        d_req = 1; d_addr = 32'h300;
        step();
        chk("rm_in_data", 32'(mem_req), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_mem_req", 32'(mem_req), 32'h0);
        chk("rm_mem_addr", mem_addr, 32'h0);
        chk("rm_d_rdata", d_rdata, 32'h0);
        chk("rm_if_rdata", if_rdata, 32'h0);
        chk("rm_stall_all", 32'(stall_all), 32'h0);
        mem_ready = 1; mem_rdata = 32'h12345678;
        step();
        d_req = 0; mem_ready = 0; rst_n = 1'b1;
        step();
        chk("rm_no_done", 32'(d_done), 32'h0);
        chk("rm_idle", 32'(mem_req), 32'h0);
        step();
        chk("rm_no_done2", 32'(d_done), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
